// File: rtl/sevenseg_scan_decoder.sv
// Receiver for a 4-digit multiplexed seven-segment bus: samples an/seg/dp,
// waits for each digit to settle, decodes it, and assembles frames scanned
// in the order 3,2,1,0. Scan-order, decode and timeout problems are flagged.
// Optional macro SEVSEG_BIN_VALUE_EN adds a binary 'value' output.
module sevenseg_scan_decoder #(
  parameter int unsigned SETTLE_CYCLES  = 16,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  an,
  input  logic [6:0]  seg,
  input  logic        dp,
  output logic [15:0] digits,
  output logic [3:0]  dp_lit,
  output logic        frame_valid,
  output logic        frame_ready,
  output logic        seg_err,
  output logic        seq_err,
  output logic        timeout
`ifdef SEVSEG_BIN_VALUE_EN
  ,
  output logic [13:0] value
`endif
);

  localparam int unsigned SW = $clog2(SETTLE_CYCLES + 1);
  localparam logic [SW-1:0] SETTLE_MAX = SW'(SETTLE_CYCLES);
  localparam logic [SW-1:0] SETTLE_HIT = SW'(SETTLE_CYCLES - 2);
  localparam logic [31:0]   TO_LAST    = 32'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_EXP2, S_EXP1, S_EXP0} state_t;

  logic [11:0]   r_samp;
  logic [11:0]   r_prev;
  logic [SW-1:0] r_cnt;
  logic [31:0]   r_to_cnt;
  logic [15:0]   r_shadow;
  logic [3:0]    r_shadow_dp;
  logic          r_commit;
  state_t        r_state;

  logic       w_same;
  logic       w_cap;
  logic [3:0] w_an;
  logic [6:0] w_lit;
  logic       w_dpl;
  logic       w_one;
  logic       w_multi;
  logic [1:0] w_idx;
  logic       w_dec_ok;
  logic [3:0] w_dig;
  logic [1:0] w_exp;
  state_t     w_adv;

  assign w_an   = r_samp[11:8];
  assign w_lit  = ~r_samp[7:1];
  assign w_dpl  = ~r_samp[0];
  assign w_same = (r_samp == r_prev);
  // Fires once per stable interval: this sample completes SETTLE_CYCLES identical ones
  assign w_cap  = w_same && (r_cnt == SETTLE_HIT);

  // Register the raw bus and keep the previous sample for the stability compare
  always_ff @(posedge clk) begin
    if (reset) begin
      r_samp <= 12'hFFF;
      r_prev <= 12'hFFF;
    end else begin
      r_samp <= {an, seg, dp};
      r_prev <= r_samp;
    end
  end

  // Stability counter, saturating at SETTLE_CYCLES so the capture cannot repeat
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (!w_same) begin
      r_cnt <= '0;
    end else if (r_cnt != SETTLE_MAX) begin
      r_cnt <= r_cnt + SW'(1);
    end
  end

  // Anode decode: which digit is selected, and whether the select is legal
  always_comb begin
    w_one   = 1'b1;
    w_multi = 1'b0;
    w_idx   = 2'd0;
    case (w_an)
      4'b1110: w_idx = 2'd0;
      4'b1101: w_idx = 2'd1;
      4'b1011: w_idx = 2'd2;
      4'b0111: w_idx = 2'd3;
      4'b1111: w_one = 1'b0;
      default: begin
        w_one   = 1'b0;
        w_multi = 1'b1;
      end
    endcase
  end

  // Segment decode, lit set in gfedcba order
  always_comb begin
    w_dec_ok = 1'b1;
    w_dig    = 4'd0;
    case (w_lit)
      7'h3F: w_dig = 4'd0;
      7'h06: w_dig = 4'd1;
      7'h5B: w_dig = 4'd2;
      7'h4F: w_dig = 4'd3;
      7'h66: w_dig = 4'd4;
      7'h6D: w_dig = 4'd5;
      7'h7D: w_dig = 4'd6;
      7'h07: w_dig = 4'd7;
      7'h7F: w_dig = 4'd8;
      7'h6F: w_dig = 4'd9;
      default: w_dec_ok = 1'b0;
    endcase
  end

  // Expected digit and advance state for the current scan position
  always_comb begin
    w_exp = 2'd3;
    w_adv = S_IDLE;
    case (r_state)
      S_EXP2: begin w_exp = 2'd2; w_adv = S_EXP1; end
      S_EXP1: begin w_exp = 2'd1; w_adv = S_EXP0; end
      S_EXP0: begin w_exp = 2'd0; w_adv = S_IDLE; end
      default: begin w_exp = 2'd3; w_adv = S_EXP2; end
    endcase
  end

  // Frame FSM, timeout supervision and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_to_cnt    <= '0;
      r_shadow    <= '0;
      r_shadow_dp <= '0;
      r_commit    <= 1'b0;
      digits      <= '0;
      dp_lit      <= '0;
      frame_valid <= 1'b0;
      frame_ready <= 1'b0;
      seg_err     <= 1'b0;
      seq_err     <= 1'b0;
      timeout     <= 1'b0;
`ifdef SEVSEG_BIN_VALUE_EN
      value       <= '0;
`endif
    end else begin
      frame_valid <= 1'b0;
      seg_err     <= 1'b0;
      seq_err     <= 1'b0;
      timeout     <= 1'b0;
      r_commit    <= 1'b0;

      if (r_commit) begin
        digits      <= r_shadow;
        dp_lit      <= r_shadow_dp;
        frame_valid <= 1'b1;
        frame_ready <= 1'b1;
`ifdef SEVSEG_BIN_VALUE_EN
        value <= 14'(r_shadow[15:12]) * 14'd1000 + 14'(r_shadow[11:8]) * 14'd100
               + 14'(r_shadow[7:4]) * 14'd10 + 14'(r_shadow[3:0]);
`endif
      end

      if (w_cap && w_one) begin
        r_to_cnt <= '0;
      end else if (r_to_cnt == TO_LAST) begin
        r_to_cnt    <= '0;
        timeout     <= 1'b1;
        frame_ready <= 1'b0;
        r_state     <= S_IDLE;
      end else begin
        r_to_cnt <= r_to_cnt + 32'd1;
      end

      if (w_cap && w_multi) begin
        seq_err <= 1'b1;
      end else if (w_cap && w_one) begin
        if (!w_dec_ok) begin
          seg_err <= 1'b1;
          r_state <= S_IDLE;
        end else if (r_state == S_IDLE) begin
          if (w_idx == 2'd3) begin
            r_shadow[15:12] <= w_dig;
            r_shadow_dp[3]  <= w_dpl;
            r_state         <= S_EXP2;
          end
        end else if (w_idx == w_exp) begin
          r_shadow[{w_idx, 2'b00} +: 4] <= w_dig;
          r_shadow_dp[w_idx]            <= w_dpl;
          r_state                       <= w_adv;
          if (r_state == S_EXP0) r_commit <= 1'b1;
        end else if (w_idx == 2'd3) begin
          seq_err         <= 1'b1;
          r_shadow[15:12] <= w_dig;
          r_shadow_dp[3]  <= w_dpl;
          r_state         <= S_EXP2;
        end else begin
          seq_err <= 1'b1;
          r_state <= S_IDLE;
        end
      end
    end
  end

endmodule
